// File: rtl/gb_video_pkg.sv
// Shared video definitions for the LCD capture path: screen geometry,
// the 2bpp pixel type and the capture FSM state encoding.
package gb_video_pkg;

  localparam int LCD_W = 160;
  localparam int LCD_H = 144;

  typedef logic [1:0] pixel_t;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    ACTIVE  = 2'd1,
    DRAIN   = 2'd2
  } cap_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; push and pop each take one
// cycle, and a push into a full FIFO is accepted only when a pop frees a slot.
module sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW:0]  wr_ptr_q, wr_ptr_d;
  logic [PW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[PW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, 1'b1};
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/lcd_capture.sv
// Captures the PPU LCD pixel stream, packs 8 2bpp pixels per 16-bit word and
// writes them to a framebuffer. Optional LCD_CAPTURE_DOUBLE_BUFFER_EN adds a
// buffer-select address MSB and a front_buf output.
//
// Write port: a word transfers in a cycle with fb_valid=1 and fb_ready=1;
// while fb_valid=1 and fb_ready=0, fb_addr/fb_data hold and fb_valid stays high.
module lcd_capture
  import gb_video_pkg::*;
#(
  parameter int H_PIXELS   = LCD_W,
  parameter int V_LINES    = LCD_H,
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hs,
  input  logic          vs,
  input  logic          cpl,
  input  logic [1:0]    pixel,
  input  logic          valid,
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
  output logic [AW:0]   fb_addr,
  output logic          front_buf,
`else
  output logic [AW-1:0] fb_addr,
`endif
  output logic [15:0]   fb_data,
  output logic          fb_valid,
  input  logic          fb_ready,
  output logic          frame_done,
  output logic          overflow,
  output logic [1:0]    state_dbg
);

`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
  localparam int FAW = AW + 1;
`else
  localparam int FAW = AW;
`endif
  localparam int FW = FAW + 16;
  localparam int XW = $clog2(H_PIXELS + 1);
  localparam int YW = $clog2(V_LINES + 1);

  localparam logic [XW-1:0] X_END      = XW'(H_PIXELS);
  localparam logic [YW-1:0] Y_END      = YW'(V_LINES);
  localparam logic [AW-1:0] LINE_WORDS = AW'(H_PIXELS / 8);

  cap_state_t    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [YW-1:0] y_inc;
  logic [AW-1:0] base_q, base_d;
  logic [13:0]   sr_q, sr_d;
  logic          frame_done_q, frame_done_d;
  logic          overflow_q, overflow_d;
  logic          cpl_q, hs_q, vs_q;

  pixel_t        pix_in;
  logic          cpl_rise, hs_fall, vs_fall, strobe;
  logic          push, pop;
  logic          fifo_full, fifo_empty;
  logic [AW-1:0] word_addr;
  logic [15:0]   word;
  logic [FW-1:0] push_word, head;

`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
  logic          wr_buf_q, wr_buf_d;
  logic          front_buf_q, front_buf_d;
`endif

  assign pix_in   = pixel;
  assign cpl_rise = cpl & ~cpl_q;
  assign hs_fall  = ~hs & hs_q;
  assign vs_fall  = ~vs & vs_q;
  assign strobe   = cpl_rise & valid & (x_q < X_END);
  assign y_inc    = y_q + YW'(1);

  // The newest pixel lands in the MSBs, so after 8 shifts the first pixel of
  // the group sits in bits [1:0].
  assign word      = {pix_in, sr_q};
  assign word_addr = base_q + AW'(x_q >> 3);

`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
  assign push_word = {wr_buf_q, word_addr, word};
`else
  assign push_word = {word_addr, word};
`endif

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    base_d       = base_q;
    sr_d         = sr_q;
    push         = 1'b0;
    frame_done_d = 1'b0;
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
    wr_buf_d     = wr_buf_q;
    front_buf_d  = front_buf_q;
`endif
    case (state_q)
      WAIT_VS: begin
        if (vs_fall) begin
          state_d = ACTIVE;
          x_d     = '0;
          y_d     = '0;
          base_d  = '0;
        end
      end
      ACTIVE: begin
        if (strobe) begin
          sr_d = {pix_in, sr_q[13:2]};
          x_d  = x_q + XW'(1);
          push = (x_q[2:0] == 3'd7);
        end
        // A word completed in the same cycle is pushed with the old line
        // base; the counters below only affect the following cycle.
        if (vs_fall) begin
          x_d    = '0;
          y_d    = '0;
          base_d = '0;
        end else if (hs_fall) begin
          x_d    = '0;
          y_d    = y_inc;
          base_d = base_q + LINE_WORDS;
          if (y_inc == Y_END) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          frame_done_d = 1'b1;
          state_d      = WAIT_VS;
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
          front_buf_d  = wr_buf_q;
          wr_buf_d     = ~wr_buf_q;
`endif
        end
      end
      default: begin
        state_d = WAIT_VS;
      end
    endcase
    overflow_d = overflow_q | (push & fifo_full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_VS;
      x_q          <= '0;
      y_q          <= '0;
      base_q       <= '0;
      sr_q         <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      cpl_q        <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
      wr_buf_q     <= 1'b1;
      front_buf_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      base_q       <= base_d;
      sr_q         <= sr_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      cpl_q        <= cpl;
      hs_q         <= hs;
      vs_q         <= vs;
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
      wr_buf_q     <= wr_buf_d;
      front_buf_q  <= front_buf_d;
`endif
    end
  end

  sync_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_word),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pop        = fb_valid & fb_ready;
  assign fb_valid   = ~fifo_empty;
  assign fb_addr    = fifo_empty ? '0 : head[FW-1:16];
  assign fb_data    = fifo_empty ? '0 : head[15:0];
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign state_dbg  = state_q;
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
  assign front_buf  = front_buf_q;
`endif

endmodule

// File: tb/tb_lcd_capture.sv
// Randomised bench for lcd_capture: a pixel-level frame model predicts every
// framebuffer write into a queue that a negedge monitor drains and compares.
module tb_lcd_capture;
  import gb_video_pkg::*;

  localparam int H     = LCD_W;
  localparam int V     = LCD_H;
  localparam int DEPTH = 4;
  localparam int AW    = 12;
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
  localparam int FAW = AW + 1;
`else
  localparam int FAW = AW;
`endif
  localparam int EW = FAW + 16;

  logic           clk = 1'b0;
  logic           rst, hs, vs, cpl, valid, fb_ready;
  logic [1:0]     pixel;
  logic [FAW-1:0] fb_addr;
  logic [15:0]    fb_data;
  logic           fb_valid, frame_done, overflow;
  logic [1:0]     state_dbg;
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
  logic           front_buf;
`endif

  lcd_capture #(
    .H_PIXELS   (H),
    .V_LINES    (V),
    .FIFO_DEPTH (DEPTH),
    .AW         (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hs         (hs),
    .vs         (vs),
    .cpl        (cpl),
    .pixel      (pixel),
    .valid      (valid),
    .fb_addr    (fb_addr),
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
    .front_buf  (front_buf),
`endif
    .fb_data    (fb_data),
    .fb_valid   (fb_valid),
    .fb_ready   (fb_ready),
    .frame_done (frame_done),
    .overflow   (overflow),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            wr_count = 0;
  int            fd_count = 0;

  // Reference model of the frame: position, partial word, buffer and flags.
  bit            m_active = 0;
  int            m_x = 0;
  int            m_y = 0;
  logic [15:0]   m_acc = '0;
  bit            m_ovf = 0;
  bit            m_wr_buf = 1;
  bit            m_front = 0;

  int            ready_mode = 1;  // 0: hold low, 1: hold high, 2: random
  int            low_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_pixel(input logic [1:0] p, input logic v);
    int            addr;
    logic [FAW-1:0] a;
    if (!v || !m_active || m_x >= H) return;
    m_acc = m_acc | (16'(p) << (2 * (m_x % 8)));
    if (m_x % 8 == 7) begin
      addr = m_y * (H / 8) + m_x / 8;
      a = FAW'(addr);
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
      a[AW] = m_wr_buf;
`endif
      if (exp_q.size() >= DEPTH) m_ovf = 1;
      else exp_q.push_back({a, m_acc});
      m_acc = '0;
    end
    m_x++;
  endtask

  task automatic model_hs();
    if (!m_active) return;
    m_y++;
    m_x = 0;
    m_acc = '0;
    if (m_y == V) m_active = 0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_active = 0;
    m_x = 0;
    m_y = 0;
    m_acc = '0;
    m_ovf = 0;
    m_wr_buf = 1;
    m_front = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_px(input logic [1:0] p, input logic v);
    @(posedge clk); #1;
    cpl = 1'b1;
    valid = v;
    pixel = p;
    model_pixel(p, v);
    @(posedge clk); #1;
    cpl = 1'b0;
    valid = 1'b0;
  endtask

  task automatic pulse_hs();
    @(posedge clk); #1;
    hs = 1'b0;
    model_hs();
    @(posedge clk); #1;
    hs = 1'b1;
  endtask

  task automatic pulse_vs();
    @(posedge clk); #1;
    vs = 1'b0;
    m_active = 1;
    m_x = 0;
    m_y = 0;
    m_acc = '0;
    @(posedge clk); #1;
    vs = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || fb_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, (n < budget), 1);
  endtask

  task automatic wait_frame_done(input string name, input int target, input int budget);
    int n = 0;
    while (fd_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, (n < budget), 1);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_fb_valid"}, fb_valid, 0);
    check({name, "_fb_addr"}, fb_addr, 0);
    check({name, "_fb_data"}, fb_data, 0);
    check({name, "_frame_done"}, frame_done, 0);
    check({name, "_overflow"}, overflow, 0);
    check({name, "_state"}, state_dbg, WAIT_VS);
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
    check({name, "_front_buf"}, front_buf, 0);
`endif
  endtask

  task automatic end_of_frame(input string name);
    m_front = m_wr_buf;
    m_wr_buf = ~m_wr_buf;
    @(negedge clk);
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
    check({name, "_front_buf"}, front_buf, m_front);
`endif
    check({name, "_state"}, state_dbg, WAIT_VS);
  endtask

  // ---------------- ready generator ----------------
  initial begin
    fb_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: fb_ready = 1'b0;
        1: fb_ready = 1'b1;
        default: begin
          if (low_run >= 3) fb_ready = 1'b1;
          else fb_ready = ($urandom_range(0, 2) != 0);
          low_run = fb_ready ? 0 : low_run + 1;
        end
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (fb_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", fb_addr, fb_data);
          end else if (fb_ready) begin
            e = exp_q.pop_front();
            check("write", {fb_addr, fb_data}, e);
            wr_count++;
          end else begin
            check("stall_hold", {fb_addr, fb_data}, exp_q[0]);
          end
        end
        if (frame_done) begin
          fd_count++;
          check("frame_done_after_drain", exp_q.size(), 0);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] pat[8];
    int         w0, fd0;
    rst = 1'b1;
    hs = 1'b1;
    vs = 1'b1;
    cpl = 1'b0;
    valid = 1'b0;
    pixel = 2'd0;
    pat = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

    do_reset();
    @(negedge clk);
    check_idle_outputs("reset");

    // Pixels before any vs fall are discarded.
    for (int i = 0; i < 16; i++) drive_px(2'($urandom_range(0, 3)), 1'b1);
    repeat (4) @(negedge clk);
    check("pre_vs_ignored", fb_valid, 0);

    // Line 0: known pattern with latency check, then 13 strobes total.
    ready_mode = 1;
    pulse_vs();
    for (int i = 0; i < 7; i++) drive_px(pat[i], 1'b1);
    @(posedge clk); #1;
    cpl = 1'b1;
    valid = 1'b1;
    pixel = pat[7];
    model_pixel(pat[7], 1'b1);
    @(negedge clk);
    check("latency_before", fb_valid, 0);
    @(posedge clk); #1;
    cpl = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    check("latency_after", fb_valid, 1);
    check("first_word_data", fb_data, 16'hE4E4);
    check("first_word_addr", fb_addr[AW-1:0], 0);
    for (int i = 0; i < 5; i++) drive_px(2'($urandom_range(0, 3)), 1'b1);
    pulse_hs();

    // Line 1: 32 random pixels with random backpressure.
    ready_mode = 2;
    for (int i = 0; i < 32; i++) drive_px(2'($urandom_range(0, 3)), 1'b1);
    wait_drain("line1_drain", 200);

    // Stall: 40 strobes with fb_ready low.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 40; i++) drive_px(2'($urandom_range(0, 3)), 1'b1);
    @(negedge clk);
    check("stall_overflow", overflow, m_ovf);
    check("stall_valid", fb_valid, 1);
    w0 = wr_count;
    ready_mode = 1;
    wait_drain("stall_drain", 50);
    check("stall_write_count", wr_count - w0, 4);
    check("overflow_sticky", overflow, 1);

    // Reset mid-line while a write is pending.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 8; i++) drive_px(2'($urandom_range(0, 3)), 1'b1);
    begin
      int n = 0;
      while (!fb_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("pending_before_reset", fb_valid, 1);
    end
    do_reset();
    @(negedge clk);
    check_idle_outputs("midline_reset");
    ready_mode = 1;
    for (int i = 0; i < 16; i++) drive_px(2'($urandom_range(0, 3)), 1'b1);
    pulse_hs();
    repeat (4) @(negedge clk);
    check("post_reset_ignored", fb_valid, 0);

    // Full frame of pixel value 1 with fb_ready held high.
    w0 = wr_count;
    fd0 = fd_count;
    pulse_vs();
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) drive_px(2'd1, 1'b1);
      pulse_hs();
    end
    wait_frame_done("full_frame_done", fd0 + 1, 200);
    end_of_frame("full_frame");
    repeat (20) @(negedge clk);
    check("full_frame_done_count", fd_count - fd0, 1);
    check("full_frame_writes", wr_count - w0, V * H / 8);
    check("full_frame_overflow", overflow, 0);

    // Short-line frame: random pixels, random valid, random backpressure.
    ready_mode = 2;
    fd0 = fd_count;
    pulse_vs();
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < 10; x++) drive_px(2'($urandom_range(0, 3)), ($urandom_range(0, 4) != 0));
      pulse_hs();
    end
    wait_frame_done("short_frame_done", fd0 + 1, 200);
    end_of_frame("short_frame");
    repeat (20) @(negedge clk);
    check("short_frame_done_count", fd_count - fd0, 1);
    check("short_frame_overflow", overflow, 0);
    wait_drain("final_drain", 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
